// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
//
// Write-domain half of an asynchronous FIFO. Brings the Gray-coded read
// pointer into the wclk domain through a two-flop synchronizer and keeps the
// binary and Gray write pointers. From these it derives the memory write
// address, a registered full flag, a fill level, an optional almost-full
// warning and a sticky overflow flag.
//
// Configuration macro: FIFO_WPTR_ALMOST_FULL_EN
//   defined   : walmost_full is registered from a level >= DEPTH-AFULL_GAP
//               comparison.
//   undefined : walmost_full is tied to 0 and no threshold logic is built.
//
// Parameters:
//   ADDRSIZE     memory address width, DEPTH = 1 << ADDRSIZE
//   AFULL_GAP    almost-full gap, legal range 1 .. DEPTH-1
//
// Ports:
//   wclk          in   write clock (only clock)
//   wrst          in   synchronous active-high reset
//   winc          in   write request from the producer
//   rptr          in   Gray read pointer, asynchronous to wclk
//   wovf_clr      in   clears the sticky overflow flag
//   waddr         out  binary write address to the memory
//   wptr          out  registered Gray write pointer to the read domain
//   wfull         out  registered full flag
//   wlevel        out  occupancy seen in the write domain, 0..DEPTH
//   walmost_full  out  registered almost-full flag
//   wovf          out  sticky overflow flag
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
  parameter int ADDRSIZE  = 9,
  parameter int AFULL_GAP = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;

  // Catch an illegal threshold at elaboration rather than as a silent
  // comparator that never (or always) fires.
  if (AFULL_GAP < 1 || AFULL_GAP >= (1 << ADDRSIZE)) begin : g_gap_check
    $error("fifo_wptr_full: AFULL_GAP out of range 1..DEPTH-1");
  end

  // -------------------------------------------------------------------------
  // Read-pointer synchronizer: plain flop-to-flop, nothing in between, so
  // only one bit of the Gray code can be in flight at a time.
  // -------------------------------------------------------------------------
  logic [PW-1:0] wq1_rptr;
  logic [PW-1:0] wq2_rptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of the others; blocking here would turn
  // the two-stage synchronizer into a single stage.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state pointer arithmetic
  // -------------------------------------------------------------------------
  logic [PW-1:0] wbin;
  logic          winc_ok;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next;
  logic          wfull_next;
  logic          wovf_next;

  // The memory write-enable is this same term, so a write while full is
  // dropped both here and at the memory.
  assign winc_ok   = winc & ~wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, winc_ok};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // NOTE: every variable assigned in an always_comb gets a default before any
  // conditional logic so no path leaves it unassigned and no latch appears.
  always_comb begin
    rbin_s           = '0;
    rbin_s[PW-1]     = wq2_rptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end
  end

  // Modulo-2^PW subtraction keeps the level correct across pointer wrap.
  assign level_next = wbinnext - rbin_s;

  // Full when the write pointer is one lap ahead of the synchronized read
  // pointer: in Gray code that is the top two bits inverted, rest equal.
  assign wfull_next = (wgraynext ==
                       {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  // Set has priority over clear so an overflow in the clear cycle is kept.
  assign wovf_next = (winc & wfull) | (wovf & ~wovf_clr);

  // -------------------------------------------------------------------------
  // Pointer, flag and level registers
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= wfull_next;
      wlevel <= level_next;
      wovf   <= wovf_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // -------------------------------------------------------------------------
  // Optional almost-full warning
  // -------------------------------------------------------------------------
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AFULL_THRESH = PW'((1 << ADDRSIZE) - AFULL_GAP);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (level_next >= AFULL_THRESH);
    end
  end
`else
  assign walmost_full = 1'b0;
`endif

endmodule
